// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH general-purpose register file with two
// combinational read ports and one synchronous write port. Register 0 always reads zero.
// Optional build macro: REGFILE_BYPASS_EN, which forwards same-cycle write data to the read ports.
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] ReadReg1,
   input  logic [ADDR_WIDTH-1:0] ReadReg2,
   input  logic [ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2
);

   localparam int unsigned NREG = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [NREG];
   logic                  w_wr_en;
   logic [DATA_WIDTH-1:0] w_rd1;
   logic [DATA_WIDTH-1:0] w_rd2;

   // A write only counts when enabled, out of reset, and not aimed at register 0
   assign w_wr_en = RegWrite && !rst && (WriteReg != '0);

   // Storage: synchronous clear on reset (wins over a write), otherwise one write per edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[WriteReg] <= WriteData;
      end
   end

   // Read port 1: register 0 forced to zero, optional forwarding of the in-flight write
   always_comb begin
      w_rd1 = '0;
      if (ReadReg1 != '0) begin
         w_rd1 = r_regs[ReadReg1];
`ifdef REGFILE_BYPASS_EN
         if (w_wr_en && (WriteReg == ReadReg1)) begin
            w_rd1 = WriteData;
         end
`endif
      end
   end

   // Read port 2: same rules as port 1, fully independent
   always_comb begin
      w_rd2 = '0;
      if (ReadReg2 != '0) begin
         w_rd2 = r_regs[ReadReg2];
`ifdef REGFILE_BYPASS_EN
         if (w_wr_en && (WriteReg == ReadReg2)) begin
            w_rd2 = WriteData;
         end
`endif
      end
   end

   assign ReadData1 = w_rd1;
   assign ReadData2 = w_rd2;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed test-plan sequences plus randomized traffic, checked against
// an array model of the register file. Honours REGFILE_BYPASS_EN the same way as the design.
module tb_register_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 32;

   logic          clk;
   logic          rst;
   logic [AW-1:0] ReadReg1;
   logic [AW-1:0] ReadReg2;
   logic [AW-1:0] WriteReg;
   logic [DW-1:0] WriteData;
   logic          RegWrite;
   logic [DW-1:0] ReadData1;
   logic [DW-1:0] ReadData2;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain array plus "contents known" flags (unknown until reset/write)
   logic [DW-1:0] m_regs  [NR];
   bit            m_known [NR];
   bit            cmp_en;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each rising edge, from the inputs presented in that cycle
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NR); i++) begin
            m_regs[i]  = '0;
            m_known[i] = 1'b1;
         end
      end else if (RegWrite && WriteReg != 0) begin
         m_regs[WriteReg]  = WriteData;
         m_known[WriteReg] = 1'b1;
      end
   end

   // Is the expected value for this address determinable (returns 0 if not)
   function automatic bit exp_ok(input logic [AW-1:0] a);
      if (a == 0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
      if (!rst && RegWrite && WriteReg != 0 && WriteReg == a) return 1'b1;
`endif
      return m_known[a];
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (!rst && RegWrite && WriteReg != 0 && WriteReg == a) return WriteData;
`endif
      return m_regs[a];
   endfunction

   // Every-cycle comparison, sampled mid-cycle away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         if (exp_ok(ReadReg1)) chk("model_rd1", ReadData1, exp_rd(ReadReg1));
         if (exp_ok(ReadReg2)) chk("model_rd2", ReadData2, exp_rd(ReadReg2));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      RegWrite  = 1'b1;
      WriteReg  = a;
      WriteData = d;
      step();
      RegWrite  = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      ReadReg1 = a1;
      ReadReg2 = a2;
      @(negedge clk);
      chk({name, "_rd1"}, ReadData1, e1);
      chk({name, "_rd2"}, ReadData2, e2);
   endtask

   logic [DW-1:0] exp_same;

   initial begin
      for (int i = 0; i < int'(NR); i++) m_known[i] = 1'b0;
      clk       = 1'b0;
      cmp_en    = 1'b1;
      rst       = 1'b1;
      RegWrite  = 1'b0;
      WriteReg  = '0;
      WriteData = '0;
      ReadReg1  = '0;
      ReadReg2  = '0;

      // Reset for one edge, then every address reads zero
      step();
      rst = 1'b0;
      for (int i = 0; i < int'(NR); i++) begin
         rd_chk("reset", AW'(i), AW'(NR - 1 - i), '0, '0);
      end

      // Sequential writes, then directed read pairs
      wr(5'd0, 32'd20);
      wr(5'd2, 32'd40);
      wr(5'd4, 32'd80);
      wr(5'd8, 32'd160);
      wr(5'd16, 32'd320);
      wr(5'd31, 32'd640);
      rd_chk("seq_0_2", 5'd0, 5'd2, 32'd0, 32'd40);
      rd_chk("seq_4_8", 5'd4, 5'd8, 32'd80, 32'd160);
      rd_chk("seq_16_31", 5'd16, 5'd31, 32'd320, 32'd640);
      chk("model_pin_r31", m_regs[31], 32'd640);

      // Write disabled: reg 5 keeps its reset value
      RegWrite  = 1'b0;
      WriteReg  = 5'd5;
      WriteData = 32'hDEADBEEF;
      ReadReg1  = 5'd5;
      repeat (4) step();
      rd_chk("wr_disabled", 5'd5, 5'd5, 32'd0, 32'd0);

      // Reset has priority over a same-edge write
      rst       = 1'b1;
      RegWrite  = 1'b1;
      WriteReg  = 5'd7;
      WriteData = 32'd99;
      step();
      rst      = 1'b0;
      RegWrite = 1'b0;
      rd_chk("rst_prio", 5'd7, 5'd16, 32'd0, 32'd0);
      wr(5'd7, 32'd99);
      rd_chk("post_rst_wr", 5'd7, 5'd7, 32'd99, 32'd99);

      // Same-cycle read/write of reg 3
      wr(5'd3, 32'd11);
      RegWrite  = 1'b1;
      WriteReg  = 5'd3;
      WriteData = 32'd22;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'd22;
`else
      exp_same = 32'd11;
`endif
      rd_chk("same_cyc_pre", 5'd3, 5'd3, exp_same, exp_same);
      step();
      RegWrite = 1'b0;
      rd_chk("same_cyc_post", 5'd3, 5'd3, 32'd22, 32'd22);

      // Writing register 0 never becomes visible, forwarded or stored
      RegWrite  = 1'b1;
      WriteReg  = 5'd0;
      WriteData = 32'd55;
      rd_chk("r0_pre", 5'd0, 5'd0, 32'd0, 32'd0);
      step();
      RegWrite = 1'b0;
      rd_chk("r0_post", 5'd0, 5'd0, 32'd0, 32'd0);

      // Randomized traffic; the every-cycle compare process does the checking
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         RegWrite  = ($urandom_range(0, 3) != 0);
         WriteReg  = AW'($urandom_range(0, NR - 1));
         WriteData = $urandom();
         ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : AW'($urandom_range(0, NR - 1));
         ReadReg2  = ($urandom_range(0, 3) == 0) ? WriteReg : AW'($urandom_range(0, NR - 1));
         step();
      end
      rst      = 1'b0;
      RegWrite = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
